// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and instruction fetch sequencer over a req/gnt/rvalid bus.
// Arbitrates interrupt and jump redirects, applies ID hold and raises pipeline flush.
module pc_fetch_ctrl #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_ADDR = '0,
    parameter int unsigned          PC_STEP    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_jump_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              irq_req_i,
    input  logic [ADDR_W-1:0] irq_vec_i,
    output logic              irq_ack_o,
    input  logic              id_hold_i,
    output logic              ifetch_req_o,
    output logic [ADDR_W-1:0] ifetch_addr_o,
    input  logic              ifetch_gnt_i,
    input  logic              ifetch_rvalid_i,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              flush_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_vld_q, pend_vld_d;
    logic              pend_irq_q, pend_irq_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    logic              take_irq_c;
    logic              take_jump_c;
    logic              redir_c;
    logic [ADDR_W-1:0] redir_addr_c;
    logic              req_c;
    logic              inst_valid_c;

    // A pending interrupt redirect must not be displaced by a later jump.
    always_comb begin
        take_irq_c   = irq_req_i;
        take_jump_c  = ex_jump_i && !irq_req_i && !(pend_vld_q && pend_irq_q);
        redir_c      = take_irq_c || take_jump_c;
        redir_addr_c = take_irq_c ? irq_vec_i : ex_jump_addr_i;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_vld_d   = pend_vld_q;
        pend_irq_d   = pend_irq_q;
        pend_addr_d  = pend_addr_q;
        req_c        = 1'b0;
        inst_valid_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redir_c) begin
                    pc_d = redir_addr_c;
                end
            end

            S_REQ: begin
                req_c = !id_hold_i;
                if (req_c && ifetch_gnt_i) begin
                    state_d = S_RESP;
                    // Granted fetch is in flight; defer the redirect until it returns.
                    if (redir_c) begin
                        pend_vld_d  = 1'b1;
                        pend_irq_d  = take_irq_c;
                        pend_addr_d = redir_addr_c;
                    end
                end else if (redir_c) begin
                    pc_d = redir_addr_c;
                end
            end

            S_RESP: begin
                if (ifetch_rvalid_i) begin
                    state_d    = S_REQ;
                    pend_vld_d = 1'b0;
                    pend_irq_d = 1'b0;
                    if (redir_c) begin
                        pc_d = redir_addr_c;
                    end else if (pend_vld_q) begin
                        pc_d = pend_addr_q;
                    end else begin
                        inst_valid_c = 1'b1;
                        pc_d         = pc_q + ADDR_W'(PC_STEP);
                    end
                end else if (redir_c) begin
                    pend_vld_d  = 1'b1;
                    pend_irq_d  = take_irq_c;
                    pend_addr_d = redir_addr_c;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_ADDR;
            pend_vld_q  <= 1'b0;
            pend_irq_q  <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_vld_q  <= pend_vld_d;
            pend_irq_q  <= pend_irq_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign pc_o          = pc_q;
    assign ifetch_addr_o = pc_q;
    assign ifetch_req_o  = req_c;
    assign inst_valid_o  = inst_valid_c;
    assign irq_ack_o     = take_irq_c;
    assign flush_o       = redir_c;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_pc_fetch_ctrl;

    localparam int unsigned ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              ex_jump_i;
    logic [ADDR_W-1:0] ex_jump_addr_i;
    logic              irq_req_i;
    logic [ADDR_W-1:0] irq_vec_i;
    logic              irq_ack_o;
    logic              id_hold_i;
    logic              ifetch_req_o;
    logic [ADDR_W-1:0] ifetch_addr_o;
    logic              ifetch_gnt_i;
    logic              ifetch_rvalid_i;
    logic              inst_valid_o;
    logic [ADDR_W-1:0] pc_o;
    logic              flush_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_ctrl #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (32'h0000_0000),
        .PC_STEP    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_jump_i       (ex_jump_i),
        .ex_jump_addr_i  (ex_jump_addr_i),
        .irq_req_i       (irq_req_i),
        .irq_vec_i       (irq_vec_i),
        .irq_ack_o       (irq_ack_o),
        .id_hold_i       (id_hold_i),
        .ifetch_req_o    (ifetch_req_o),
        .ifetch_addr_o   (ifetch_addr_o),
        .ifetch_gnt_i    (ifetch_gnt_i),
        .ifetch_rvalid_i (ifetch_rvalid_i),
        .inst_valid_o    (inst_valid_o),
        .pc_o            (pc_o),
        .flush_o         (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic gnt, input logic rvalid, input logic hold);
        ifetch_gnt_i    = gnt;
        ifetch_rvalid_i = rvalid;
        id_hold_i       = hold;
        #1;
    endtask

    initial begin
        rst             = 1'b0;
        ex_jump_i       = 1'b0;
        ex_jump_addr_i  = '0;
        irq_req_i       = 1'b0;
        irq_vec_i       = '0;
        id_hold_i       = 1'b0;
        ifetch_gnt_i    = 1'b0;
        ifetch_rvalid_i = 1'b0;

        // Reset values
        step();
        #1;
        check("rst_pc", pc_o, 32'h0);
        check("rst_addr", ifetch_addr_o, 32'h0);
        check("rst_req", 32'(ifetch_req_o), 32'h0);
        check("rst_ival", 32'(inst_valid_o), 32'h0);
        check("rst_ack", 32'(irq_ack_o), 32'h0);
        check("rst_flush", 32'(flush_o), 32'h0);

        // Free run: IDLE then fetch 0x0, 0x4, reach 0x8
        step();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        check("idle_req", 32'(ifetch_req_o), 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b0);
        check("f0_req", 32'(ifetch_req_o), 32'h1);
        check("f0_addr", ifetch_addr_o, 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b0);
        check("f0_resp_req", 32'(ifetch_req_o), 32'h0);
        check("f0_ival", 32'(inst_valid_o), 32'h1);
        check("f0_flush", 32'(flush_o), 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b0);
        check("f1_addr", ifetch_addr_o, 32'h4);
        check("f1_ival", 32'(inst_valid_o), 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b0);
        check("f1_ival", 32'(inst_valid_o), 32'h1);
        check("f1_ack", 32'(irq_ack_o), 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b0);
        check("f2_addr", ifetch_addr_o, 32'h8);

        // Jump to 0x100 while the 0x8 response is outstanding
        step();
        ex_jump_i      = 1'b1;
        ex_jump_addr_i = 32'h100;
        drive(1'b0, 1'b0, 1'b0);
        check("jmp_flush", 32'(flush_o), 32'h1);
        check("jmp_ival", 32'(inst_valid_o), 32'h0);
        step();
        ex_jump_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        check("jmp_flush_end", 32'(flush_o), 32'h0);
        check("jmp_pc_held", pc_o, 32'h8);
        step();
        drive(1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0);
        check("jmp_discard", 32'(inst_valid_o), 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0);
        check("jmp_addr", ifetch_addr_o, 32'h100);
        check("jmp_req", 32'(ifetch_req_o), 32'h1);

        // Same-cycle irq and jump in REQ without grant: irq wins
        irq_req_i      = 1'b1;
        irq_vec_i      = 32'h80;
        ex_jump_i      = 1'b1;
        ex_jump_addr_i = 32'h200;
        #1;
        check("irq_ack", 32'(irq_ack_o), 32'h1);
        check("irq_flush", 32'(flush_o), 32'h1);
        step();
        irq_req_i = 1'b0;
        ex_jump_i = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        check("irq_pc", pc_o, 32'h80);
        check("irq_ack_end", 32'(irq_ack_o), 32'h0);
        step();

        // Hold asserted in RESP does not suppress the response
        drive(1'b0, 1'b1, 1'b1);
        check("resp_hold_ival", 32'(inst_valid_o), 32'h1);
        step();
        check("hold_pc_start", pc_o, 32'h84);

        // ID hold 3 cycles in REQ with grant tied high
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1);
            check("hold_req", 32'(ifetch_req_o), 32'h0);
            check("hold_pc", pc_o, 32'h84);
            step();
        end
        drive(1'b1, 1'b0, 1'b0);
        check("unhold_req", 32'(ifetch_req_o), 32'h1);
        check("unhold_addr", ifetch_addr_o, 32'h84);
        step();
        drive(1'b0, 1'b1, 1'b0);
        check("unhold_ival", 32'(inst_valid_o), 32'h1);
        step();
        check("after_hold_pc", pc_o, 32'h88);

        // Wrap: redirect to 0xFFFF_FFFC then fetch sequentially
        ex_jump_i      = 1'b1;
        ex_jump_addr_i = 32'hFFFF_FFFC;
        drive(1'b0, 1'b0, 1'b0);
        step();
        ex_jump_i = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        check("wrap_addr", ifetch_addr_o, 32'hFFFF_FFFC);
        step();
        drive(1'b0, 1'b1, 1'b0);
        check("wrap_ival", 32'(inst_valid_o), 32'h1);
        step();
        check("wrap_pc", pc_o, 32'h0);

        // Pending irq captured on grant is not displaced by a later jump
        irq_req_i = 1'b1;
        irq_vec_i = 32'h40;
        drive(1'b1, 1'b0, 1'b0);
        check("pirq_ack", 32'(irq_ack_o), 32'h1);
        step();
        irq_req_i      = 1'b0;
        ex_jump_i      = 1'b1;
        ex_jump_addr_i = 32'h300;
        drive(1'b0, 1'b0, 1'b0);
        check("pirq_jmp_drop", 32'(flush_o), 32'h0);
        step();
        ex_jump_i = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        check("pirq_discard", 32'(inst_valid_o), 32'h0);
        step();
        check("pirq_pc", pc_o, 32'h40);

        // Async reset mid-RESP at pc 0x10
        ex_jump_i      = 1'b1;
        ex_jump_addr_i = 32'h10;
        drive(1'b0, 1'b0, 1'b0);
        step();
        ex_jump_i = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        check("ar_addr", ifetch_addr_o, 32'h10);
        step();
        drive(1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_pc", pc_o, 32'h0);
        ifetch_rvalid_i = 1'b1;
        #1;
        check("ar_ival_in_rst", 32'(inst_valid_o), 32'h0);
        step();
        check("ar_ival_edge", 32'(inst_valid_o), 32'h0);
        rst = 1'b1;
        #1;
        check("ar_idle_ival", 32'(inst_valid_o), 32'h0);
        check("ar_idle_req", 32'(ifetch_req_o), 32'h0);
        step();
        drive(1'b0, 1'b1, 1'b0);
        check("ar_req_ival", 32'(inst_valid_o), 32'h0);
        check("ar_restart_req", 32'(ifetch_req_o), 32'h1);
        check("ar_restart_addr", ifetch_addr_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the program counter and sequences instruction fetch over a request/grant/response bus.
- Arbitrates PC redirection between the interrupt controller and EX-stage jumps.
- Applies ID-stage hold and generates the pipeline flush.
- Sits between the IF stage and the instruction bus; replaces free-running PC increment with a bus-aware fetch FSM.

Parameters:
ADDR_W, 32, PC / fetch address width
RESET_ADDR, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential instruction

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (rst==0 resets)
ex_jump_i  in  1  EX-stage jump/branch taken
ex_jump_addr_i  in  ADDR_W  jump target
irq_req_i  in  1  interrupt redirect request (level)
irq_vec_i  in  ADDR_W  interrupt vector address
irq_ack_o  out  1  one-cycle pulse: interrupt redirect accepted
id_hold_i  in  1  ID stall (load-use); blocks new fetch requests
ifetch_req_o  out  1  fetch request
ifetch_addr_o  out  ADDR_W  fetch address (= pc_o)
ifetch_gnt_i  in  1  bus accepted request this cycle
ifetch_rvalid_i  in  1  instruction data valid this cycle
inst_valid_o  out  1  fetched instruction valid for IF/ID register
pc_o  out  ADDR_W  current fetch PC / PC of the instruction under fetch
flush_o  out  1  kill younger instructions in IF/ID

Behaviour:
- Reset (rst low, async): state=IDLE, pc_o=RESET_ADDR, pend_vld=0, pend_addr=0; all outputs 0 except pc_o/ifetch_addr_o=RESET_ADDR.
- States: IDLE, REQ, RESP.
- IDLE: one cycle after reset release; goes to REQ.
- REQ: ifetch_req_o = !id_hold_i. Transitions to RESP on ifetch_gnt_i && ifetch_req_o. ifetch_gnt_i is ignored while ifetch_req_o=0.
- RESP: ifetch_req_o=0; waits for ifetch_rvalid_i with no timeout. On rvalid:
  - pend_vld or a redirect accepted this cycle: response discarded (inst_valid_o=0); pc_o<=target; pend_vld<=0; go to REQ.
  - otherwise: inst_valid_o=1 (combinational, same cycle); pc_o<=pc_o+PC_STEP, modulo 2^ADDR_W; go to REQ.
- Redirect acceptance:
  - Any cycle. irq_req_i has priority over ex_jump_i.
  - irq_ack_o=1 in the accepting cycle. A same-cycle jump is dropped.
  - A new irq overwrites a pending jump. A jump never overwrites a pending irq, and is dropped.
- flush_o=1, combinational, in every cycle a redirect is accepted.
- Redirect applied directly (no pending) when accepted in IDLE, or in REQ without a grant that cycle: pc_o<=target at the next edge; state unchanged. No pulse-level address change is visible to the bus: the request was not granted.
- Redirect in REQ with grant in the same cycle, or in RESP without rvalid: captured into pend_addr, pend_vld=1. It is applied when the outstanding response returns.
- id_hold_i has no effect in RESP: the outstanding response is still consumed, and inst_valid_o still pulses. Downstream holds its register.
- Reset mid-transaction: state returns to IDLE immediately. Any later rvalid of the aborted fetch is ignored because the state is not RESP.

Test Plan:
- Reset then free-run, gnt=1 and rvalid 1 cycle after gnt -> ifetch_addr 0x0, 0x4, 0x8, one fetch per 2 cycles; inst_valid_o pulse per fetch; irq_ack_o/flush_o stay 0.
- ex_jump_i=1 with addr 0x100 while in RESP (rvalid delayed 3 cycles) -> flush_o pulse that cycle; rvalid discarded (inst_valid_o=0); next ifetch_addr=0x100.
- irq_req_i=1 with vec 0x80 and ex_jump_i=1 with addr 0x200 in the same REQ cycle, no gnt -> irq_ack_o=1, flush_o=1; pc_o=0x80 next cycle; 0x200 never fetched.
- id_hold_i high 3 cycles in REQ, gnt tied 1 -> ifetch_req_o=0 for those 3 cycles; pc_o constant; fetch resumes at the same address after hold drops.
- pc_o=0xFFFF_FFFC with a sequential fetch -> pc_o wraps to 0x0000_0000.
- rst low asynchronously mid-RESP at pc 0x10 -> pc_o=RESET_ADDR without a clock edge; rvalid asserted during/after reset yields no inst_valid_o; fetch restarts at RESET_ADDR after IDLE.
